ddr_fml_arb: RTL and testbench

- Four-port FastMemoryLink (FML) arbiter that shares the single FML slave port of the DDR controller between up to four masters, for example a video fetch, a CPU cache and DMA engines.
- Selects one requesting master round-robin and latches its complete request (type, address, data, mask).
- Replays the latched request to the controller until the controller pulses done, then routes that done pulse and the read data back to the granted master.
- Inserts one turnaround cycle between transactions so the controller's registered done never overlaps a new request.

---
 rtl/ddr_fml_arb.sv | 185 ++++++++++++++++++
 tb/tb_ddr_fml_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_fml_arb.sv
// Four-port FML arbiter: round-robin grant, latched request replay, one turnaround cycle.
// Define DDR_ARB_ROWHIT_EN to let the last master keep the port on a bank/row hit.
module ddr_fml_arb #(
    parameter int adr_width = 25,
    parameter int page_lsb  = 10,
    parameter int max_hold  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               m_wr,
    input  logic [3:0]               m_rd,
    input  logic [4*adr_width-1:0]   m_adr,
    input  logic [511:0]             m_din,
    input  logic [63:0]              m_msk,
    output logic [3:0]               m_done,
    output logic [127:0]             m_dout,
    output logic [3:0]               m_gnt,
    output logic                     s_wr,
    output logic                     s_rd,
    output logic [adr_width-1:0]     s_adr,
    output logic [127:0]             s_din,
    output logic [15:0]              s_msk,
    input  logic                     s_done,
    input  logic [127:0]             s_dout,
    output logic                     proto_err
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    if (page_lsb >= adr_width || max_hold < 1) begin : gBadCfg
        $error("ddr_fml_arb: page_lsb must be below adr_width and max_hold at least 1");
    end

    state_t                 state_q, state_d;
    logic [1:0]             last_q, last_d;
    logic [3:0]             gnt_q, gnt_d;
    logic                   swr_q, swr_d;
    logic                   srd_q, srd_d;
    logic [adr_width-1:0]   sadr_q, sadr_d;
    logic [127:0]           sdin_q, sdin_d;
    logic [15:0]            smsk_q, smsk_d;
    logic                   err_q, err_d;

    logic [3:0]             req;
    logic                   anyReq;
    logic [1:0]             rrSel;
    logic [1:0]             idx;
    logic [1:0]             sel;
    logic [adr_width-1:0]   adrArr [4];
    logic [127:0]           dinArr [4];
    logic [15:0]            mskArr [4];

    for (genvar i = 0; i < 4; i++) begin : gSlice
        assign adrArr[i] = m_adr[i*adr_width +: adr_width];
        assign dinArr[i] = m_din[i*128 +: 128];
        assign mskArr[i] = m_msk[i*16 +: 16];
    end

    assign req    = m_wr | m_rd;
    assign anyReq = |req;

    // Scanning from the far end lets the nearest requester after last overwrite the others.
    always_comb begin
        rrSel = last_q + 2'd1;
        idx   = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + 2'(k);
            if (req[idx]) rrSel = idx;
        end
    end

`ifdef DDR_ARB_ROWHIT_EN
    localparam int HW = $clog2(max_hold + 2);

    logic [HW-1:0]  hold_q, hold_d;
    logic           hitOk_q, hitOk_d;
    logic           rowHit;

    // A hit is only honoured in the first idle cycle after a turnaround.
    assign rowHit = hitOk_q && req[last_q]
                 && (adrArr[last_q][adr_width-1:page_lsb] == sadr_q[adr_width-1:page_lsb])
                 && (hold_q < HW'(max_hold));
    assign sel = rowHit ? last_q : rrSel;

    always_comb begin
        hold_d  = hold_q;
        hitOk_d = (state_q == TURN);
        if (state_q == IDLE && anyReq) begin
            if (sel != last_q)
                hold_d = '0;
            else if (hold_q < HW'(max_hold))
                hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '0;
            hitOk_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            hitOk_q <= hitOk_d;
        end
    end
`else
    assign sel = rrSel;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        swr_d   = swr_q;
        srd_d   = srd_q;
        sadr_d  = sadr_q;
        sdin_d  = sdin_q;
        smsk_d  = smsk_q;
        err_d   = err_q;
        if (|(m_wr & m_rd)) err_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (s_done) err_d = 1'b1;
                if (anyReq) begin
                    state_d = GRANT;
                    last_d  = sel;
                    gnt_d   = 4'b0001 << sel;
                    swr_d   = m_wr[sel];
                    srd_d   = ~m_wr[sel];
                    sadr_d  = adrArr[sel];
                    sdin_d  = dinArr[sel];
                    smsk_d  = mskArr[sel];
                end
            end
            GRANT: begin
                if ((gnt_q & req) == 4'b0) err_d = 1'b1;
                if (s_done) begin
                    state_d = TURN;
                    swr_d   = 1'b0;
                    srd_d   = 1'b0;
                    gnt_d   = 4'b0;
                end
            end
            TURN: begin
                if (s_done) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            gnt_q   <= 4'b0;
            swr_q   <= 1'b0;
            srd_q   <= 1'b0;
            sadr_q  <= '0;
            sdin_q  <= '0;
            smsk_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            swr_q   <= swr_d;
            srd_q   <= srd_d;
            sadr_q  <= sadr_d;
            sdin_q  <= sdin_d;
            smsk_q  <= smsk_d;
            err_q   <= err_d;
        end
    end

    assign m_done    = (state_q == GRANT && s_done) ? gnt_q : 4'b0;
    assign m_dout    = s_dout;
    assign m_gnt     = gnt_q;
    assign s_wr      = swr_q;
    assign s_rd      = srd_q;
    assign s_adr     = sadr_q;
    assign s_din     = sdin_q;
    assign s_msk     = smsk_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_ddr_fml_arb.sv
// Testbench for ddr_fml_arb: directed scenarios plus random masters and controller,
// all checked against a transaction-level model of the arbiter kept here.
module tb_ddr_fml_arb;

    localparam int AW       = 25;
    localparam int PAGE_LSB = 10;
    localparam int MAX_HOLD = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      m_wr, m_rd;
    logic [4*AW-1:0] m_adr;
    logic [511:0]    m_din;
    logic [63:0]     m_msk;
    logic [3:0]      m_done;
    logic [127:0]    m_dout;
    logic [3:0]      m_gnt;
    logic            s_wr, s_rd;
    logic [AW-1:0]   s_adr;
    logic [127:0]    s_din;
    logic [15:0]     s_msk;
    logic            s_done;
    logic [127:0]    s_dout;
    logic            proto_err;

    always #5 clk = ~clk;

    ddr_fml_arb #(.adr_width(AW), .page_lsb(PAGE_LSB), .max_hold(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .m_wr(m_wr), .m_rd(m_rd), .m_adr(m_adr), .m_din(m_din), .m_msk(m_msk),
        .m_done(m_done), .m_dout(m_dout), .m_gnt(m_gnt),
        .s_wr(s_wr), .s_rd(s_rd), .s_adr(s_adr), .s_din(s_din), .s_msk(s_msk),
        .s_done(s_done), .s_dout(s_dout), .proto_err(proto_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the port, whether we are in the dead cycle, and the replayed request.
    int            mOwner;
    int            mLast;
    bit            mTurn;
    bit            mWr, mRd, mErr;
    logic [AW-1:0] mAdr;
    logic [127:0]  mDin;
    logic [15:0]   mMsk;
`ifdef DDR_ARB_ROWHIT_EN
    int            mHold;
    bit            mFresh;
`endif

    int busyCnt = 0;
    int lat = 1;
    bit pend [4];
    bit doneSeen [4];
    int grantLog [$];

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [AW-1:0] adrOf(input int i);
        return m_adr[i*AW +: AW];
    endfunction

    task automatic modelReset();
        mOwner = -1; mLast = 3; mTurn = 0;
        mWr = 0; mRd = 0; mErr = 0;
        mAdr = '0; mDin = '0; mMsk = '0;
`ifdef DDR_ARB_ROWHIT_EN
        mHold = 0; mFresh = 0;
`endif
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelClock();
        logic [3:0] req;
        int pick;
`ifdef DDR_ARB_ROWHIT_EN
        bit wasTurn;
        wasTurn = mTurn;
`endif
        req  = m_wr | m_rd;
        pick = -1;
        if ((m_wr & m_rd) != 4'b0) mErr = 1;
        if (mTurn) begin
            if (s_done) mErr = 1;
            mTurn = 0;
        end else if (mOwner >= 0) begin
            if (!req[mOwner]) mErr = 1;
            if (s_done) begin
                mOwner = -1; mWr = 0; mRd = 0; mTurn = 1;
            end
        end else begin
            if (s_done) mErr = 1;
`ifdef DDR_ARB_ROWHIT_EN
            if (mFresh && req[mLast] && (adrOf(mLast) >> PAGE_LSB) == (mAdr >> PAGE_LSB) && mHold < MAX_HOLD)
                pick = mLast;
`endif
            for (int k = 1; k <= 4 && pick < 0; k++)
                if (req[(mLast + k) % 4]) pick = (mLast + k) % 4;
            if (pick >= 0) begin
`ifdef DDR_ARB_ROWHIT_EN
                if (pick != mLast) mHold = 0;
                else if (mHold < MAX_HOLD) mHold++;
`endif
                mOwner = pick; mLast = pick;
                mWr = m_wr[pick]; mRd = !m_wr[pick];
                mAdr = adrOf(pick);
                mDin = m_din[pick*128 +: 128];
                mMsk = m_msk[pick*16 +: 16];
            end
        end
`ifdef DDR_ARB_ROWHIT_EN
        mFresh = wasTurn;
`endif
    endtask

    task automatic checkNow();
        logic [3:0] expGnt;
        expGnt = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0;
        checkOutput("gnt", m_gnt, expGnt);
        checkOutput("sWr", s_wr, mWr);
        checkOutput("sRd", s_rd, mRd);
        checkOutput("sAdr", s_adr, mAdr);
        checkOutput("sDin", s_din, mDin);
        checkOutput("sMsk", s_msk, mMsk);
        checkOutput("mDone", m_done, s_done ? expGnt : 4'b0);
        checkOutput("mDout", m_dout, s_dout);
        checkOutput("protoErr", proto_err, mErr);
    endtask

    // Inputs are applied just after a rising edge; this checks mid-cycle, then steps to the next edge.
    task automatic cycle();
        #1;
        checkNow();
        for (int i = 0; i < 4; i++) doneSeen[i] = (mOwner == i) && s_done;
        modelClock();
        @(posedge clk);
        #1;
        if (mOwner >= 0) busyCnt++;
        else begin
            busyCnt = 0;
            lat = $urandom_range(3);
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        m_wr = '0; m_rd = '0; m_adr = '0; m_din = '0; m_msk = '0;
        s_done = 1'b0; s_dout = '0;
        modelReset();
        #1;
        checkNow();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        busyCnt = 0;
    endtask

    task automatic driveCtrl();
        s_done = (mOwner >= 0) && (busyCnt > lat);
        s_dout = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic newTxn(input int i);
        logic [AW-1:0] a;
        bit w;
        w = 1'($urandom_range(1));
        a = AW'($urandom);
        if ($urandom_range(1) == 1) a[AW-1:PAGE_LSB] = mAdr[AW-1:PAGE_LSB];
        m_wr[i] = w;
        m_rd[i] = !w;
        m_adr[i*AW +: AW]   = a;
        m_din[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        m_msk[i*16 +: 16]   = 16'($urandom);
    endtask

    // Random masters: hold a request until done, then drop or renew; the owner scribbles its data lines.
    task automatic applyStimulus();
        for (int i = 0; i < 4; i++) begin
            if (doneSeen[i]) begin
                pend[i] = ($urandom_range(1) == 1);
                if (pend[i]) newTxn(i);
                else begin
                    m_wr[i] = 1'b0;
                    m_rd[i] = 1'b0;
                end
            end else if (!pend[i]) begin
                if ($urandom_range(2) == 0) begin
                    pend[i] = 1;
                    newTxn(i);
                end
            end else if (mOwner == i) begin
                m_din[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
                m_msk[i*16 +: 16]   = 16'($urandom);
                m_adr[i*AW +: PAGE_LSB] = PAGE_LSB'($urandom);
            end
        end
        driveCtrl();
    endtask

    // Runs with the current requests held until n grant starts are logged or the budget expires.
    task automatic runGrants(input int n);
        logic [3:0] prevGnt;
        prevGnt = '0;
        grantLog.delete();
        for (int c = 0; c < 300 && grantLog.size() < n; c++) begin
            driveCtrl();
            cycle();
            if (m_gnt != 4'b0 && prevGnt == 4'b0)
                for (int i = 0; i < 4; i++) if (m_gnt[i]) grantLog.push_back(i);
            prevGnt = m_gnt;
        end
        checkOutput("grantCount", grantLog.size(), n);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expOrder [6];

        // Single master read with exact cycle timing.
        applyReset();
        m_rd[2] = 1'b1;
        m_adr[2*AW +: AW] = 25'h000100;
        cycle();
        checkOutput("t1Gnt", m_gnt, 4'b0100);
        checkOutput("t1SRd", s_rd, 1);
        checkOutput("t1SAdr", s_adr, 25'h000100);
        repeat (5) cycle();
        s_done = 1'b1;
        s_dout = {16{8'hA5}};
        #1;
        checkOutput("t1Done", m_done, 4'b0100);
        checkOutput("t1Dout", m_dout, {16{8'hA5}});
        cycle();
        s_done = 1'b0;
        m_rd[2] = 1'b0;
        checkOutput("t1TurnRd", s_rd, 0);
        checkOutput("t1TurnGnt", m_gnt, 4'b0000);
        repeat (2) cycle();

        // Write data is latched at grant and must not follow the master's lines afterwards.
        applyReset();
        m_wr[1] = 1'b1;
        m_din[1*128 +: 128] = {8{16'h1122}};
        m_msk[1*16 +: 16] = 16'h0000;
        cycle();
        checkOutput("t3SWr", s_wr, 1);
        m_din[1*128 +: 128] = {8{16'hDEAD}};
        cycle();
        checkOutput("t3DinHeld", s_din, {8{16'h1122}});
        checkOutput("t3MskHeld", s_msk, 16'h0000);
        s_done = 1'b1;
        #1;
        checkOutput("t3Done", m_done, 4'b0010);
        cycle();
        s_done = 1'b0;
        m_wr[1] = 1'b0;
        checkOutput("t3DinAfter", s_din, {8{16'h1122}});
        checkOutput("t3NoErr", proto_err, 0);
        repeat (2) cycle();

        // Write and read together: the write wins and the error sticks.
        applyReset();
        m_wr[0] = 1'b1;
        m_rd[0] = 1'b1;
        cycle();
        checkOutput("t4SWr", s_wr, 1);
        checkOutput("t4SRd", s_rd, 0);
        checkOutput("t4Err", proto_err, 1);
        s_done = 1'b1;
        cycle();
        s_done = 1'b0;
        m_wr = '0;
        m_rd = '0;
        repeat (2) cycle();

        // Reset in the middle of a grant, then a stray done.
        applyReset();
        m_rd[2] = 1'b1;
        repeat (2) cycle();
        checkOutput("t5PreGnt", m_gnt, 4'b0100);
        applyReset();
        s_done = 1'b1;
        #1;
        checkOutput("t5StrayDone", m_done, 4'b0000);
        cycle();
        s_done = 1'b0;
        checkOutput("t5Gnt", m_gnt, 4'b0000);
        checkOutput("t5Idle", {s_wr, s_rd}, 2'b00);
        m_rd[0] = 1'b1;
        cycle();
        checkOutput("t5Regrant", m_gnt, 4'b0001);
        checkOutput("t5SRd", s_rd, 1);
        s_done = 1'b1;
        cycle();
        s_done = 1'b0;
        m_rd = '0;
        repeat (2) cycle();

`ifndef DDR_ARB_ROWHIT_EN
        // Four continuous requesters rotate strictly.
        applyReset();
        for (int i = 0; i < 4; i++) m_adr[i*AW +: AW] = AW'(i << PAGE_LSB);
        m_rd = 4'b1111;
        expOrder = '{0, 1, 2, 3, 0, 1};
        runGrants(6);
        for (int i = 0; i < grantLog.size() && i < 6; i++)
            checkOutput($sformatf("rrOrder%0d", i), grantLog[i], expOrder[i]);
`else
        // Masters 0 and 3 requesting; master 0 stays on one row and keeps the port up to the hold limit.
        applyReset();
        m_adr[0*AW +: AW] = 25'h000400;
        m_adr[3*AW +: AW] = 25'h000800;
        m_rd = 4'b1001;
        expOrder = '{0, 0, 0, 0, 0, 3};
        runGrants(6);
        for (int i = 0; i < grantLog.size() && i < 6; i++)
            checkOutput($sformatf("hitOrder%0d", i), grantLog[i], expOrder[i]);
`endif
        s_done = 1'b0;

        // Random masters and controller latency.
        applyReset();
        for (int i = 0; i < 4; i++) begin
            pend[i] = 0;
            doneSeen[i] = 0;
        end
        repeat (600) begin
            applyStimulus();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
